vc_output_scheduler: RTL and testbench
======================================

# vc_output_scheduler

Per-output-port scheduler for the 5-port mesh router: arbitrates among up to four input interfaces contending for one output direction, stores the winning flit in a per-virtual-channel output buffer, and drives the outbound so/ro link handshake. Virtual channel use is phased by the router's `polarity` toggle: one VC accepts from inputs while the other VC drains to the link. One instance sits behind each output direction (E, W, N, S, PE) and replaces the separate arbiter plus output-control pair.

## Interface
- `DATA_W`, default 64: flit width.
- `N_REQ`, default 4: number of requesting input interfaces; the port's own direction is excluded.
- `clk  in  1`: clock, rising edge.
- `reset  in  1`: reset, synchronous, active-high; clock clk.
- `polarity  in  1`: router phase bit, toggles every cycle from router top.
- `req  in  N_REQ`: request from input i; valid only for the internal VC of the current phase.
- `data_in  in  N_REQ*DATA_W`: packed flits; input i occupies bits [i*DATA_W +: DATA_W].
- `grant  out  N_REQ`: one-hot grant. This is also the input-buffer clear pulse to the winner.
- `ro  in  1`: downstream ready for the external VC.
- `so  out  1`: send strobe to downstream.
- `data_out  out  DATA_W`: flit presented to downstream.
- `vc_full  out  2`: buffer occupancy; bit 0 is the even VC, bit 1 is the odd VC.

## Operation
- VC roles:
  - Internal VC `iv = polarity`: the VC that accepts from inputs.
  - External VC `ev = ~polarity`: the VC that drains to the link.
  - The two roles always select different buffers, so fill and drain never touch the same buffer.
- Storage: two DATA_W flit registers `buf[0..1]` with full bits `vc_full[1:0]`.
- Round-robin state: one pointer per VC, `ptr[0..1]`, each a log2(N_REQ)-bit value.
- Arbitration is combinational within the cycle:
  - If `vc_full[iv]==0` and `req!=0`, grant the first requester at or after `ptr[iv]`, wrapping modulo N_REQ.
  - Otherwise `grant=0`.
- On a clock edge with a grant to input k:
  - `buf[iv] <= data_in[k]`.
  - `vc_full[iv] <= 1`.
  - `ptr[iv] <= (k+1) mod N_REQ`.
  - `ptr[ev]` is unchanged.
- No grant: both pointers hold. A requester that is blocked keeps its place.
- Link side, combinational:
  - `so = vc_full[ev] & ro`.
  - `data_out = buf[ev]`.
- On a clock edge with `so==1`: `vc_full[ev] <= 0`. The flit value is held; it is not zeroed.
- Flit contents pass through unmodified.

## Timing
- Reset values:
  - `buf[*]=0`, `vc_full=2'b00`, `ptr[*]=0`.
  - Outputs therefore read `grant=0`, `so=0`, `data_out=0`.
- Reset asserted mid-operation: buffered flits are discarded. A grant issued in the reset cycle is not honoured; the buffer stays empty.
- Latency:
  - Grant to buffered: 1 edge.
  - A flit granted in phase p is eligible to send in the next cycle (phase ~p), when its VC becomes external.
  - Minimum input-to-link latency: 1 cycle.
- Full buffer: `grant=0` regardless of `req`. The input must hold its request.
- `ro=0`: the flit stays in `buf[ev]`. The buffer becomes internal again next cycle and still blocks grants until it is sent in a later external phase.
- Simultaneous events: a grant on `iv` and a send on `ev` in the same cycle are both honoured.
- `req` bits for absent neighbours are tied to 0 at router top.
- Throughput: at most one flit per cycle on the link. Each VC gets at most one flit every 2 cycles.

## Structure
- Shared package `noc_pkg`: `DATA_W`, `N_REQ`, and the port index constants `PORT_E`, `PORT_W`, `PORT_N`, `PORT_S`, `PORT_PE`.
- Sub-module `rr_pick`: combinational rotate, priority-encode, unrotate.
  - Inputs: `req[N_REQ-1:0]`, `ptr`.
  - Outputs: one-hot `gnt` and the encoded `idx`.
  - Instantiated once and fed `ptr[iv]`.
- Everything else (buffers, full bits, pointers, link mux) lives in `vc_output_scheduler`.

## Test plan
- Reset, then `polarity=0`, `req=4'b0001`, `data_in[0]=64'hA5` → `grant=4'b0001`. Next cycle (`polarity=1`) with `ro=1` → `so=1`, `data_out=64'hA5`. After that edge, `vc_full=00`.
- `req=4'b1111` held for 8 cycles, `ro=1` → grants per VC rotate 0,1,2,3. Even-phase grant sequence is 0001, 0010, 0100, 1000, with no requester granted twice before all are served.
- Fill VC0, hold `ro=0` for 6 cycles → `so=0` throughout, `data_out` stable, and no further even-phase grants. Raise `ro` → exactly one send, and VC0 grants resume.
- Simultaneous fill and drain: VC1 full, `polarity=0`, `ro=1`, `req=4'b0100` → `so=1` for VC1 and `grant=4'b0100` in the same cycle. After the edge, `vc_full=2'b01`.
- Pointer skip: `ptr[0]=2`, `req=4'b0011` → `grant=4'b0001`, and `ptr[0]` becomes 1.
- Reset pulsed with both VCs full → `vc_full=00`, `so=0`, `data_out=0` on the cycle after reset; buffered data is never emitted.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default flit geometry, port indices and
// small width helpers used by the per-output scheduler slice.
package noc_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned N_VC   = 2;

    // Router port indices (E, W, N, S, local PE).
    localparam int unsigned PORT_E  = 0;
    localparam int unsigned PORT_W  = 1;
    localparam int unsigned PORT_N  = 2;
    localparam int unsigned PORT_S  = 3;
    localparam int unsigned PORT_PE = 4;

    // Virtual channel identifiers; the VC index equals the polarity that makes it internal.
    typedef enum logic {
        VC_EVEN = 1'b0,
        VC_ODD  = 1'b1
    } vc_id_e;

    // Width of a round-robin pointer over n requesters (never zero).
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_output_scheduler_if.sv
// Output-port bundle of one scheduler: input-side req/data/grant and the
// downstream so/ro link with its flit and the VC occupancy status.
//   req      : per-input request for the current internal VC
//   data_in  : packed flits, input i at [i*DATA_W +: DATA_W]
//   grant    : one-hot grant / input-buffer clear pulse
//   ro       : downstream ready for the external VC
//   so       : send strobe to downstream
//   data_out : flit presented to downstream
//   vc_full  : VC buffer occupancy, bit 0 even VC, bit 1 odd VC
interface vc_output_scheduler_if #(
    parameter int unsigned DATA_W = noc_pkg::DATA_W,
    parameter int unsigned N_REQ  = noc_pkg::N_REQ
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] data_in;
    logic [N_REQ-1:0]        grant;
    logic                    ro;
    logic                    so;
    logic [DATA_W-1:0]       data_out;
    logic [1:0]              vc_full;

    // Scheduler side.
    modport master (
        input  req,
        input  data_in,
        input  ro,
        output grant,
        output so,
        output data_out,
        output vc_full
    );

    // Input buffers plus downstream link side.
    modport slave (
        output req,
        output data_in,
        output ro,
        input  grant,
        input  so,
        input  data_out,
        input  vc_full
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester at or after ptr,
// wrapping modulo N_REQ.
//   req : request vector
//   ptr : highest-priority index
//   gnt : one-hot grant (zero when no request)
//   idx : encoded index of the granted requester
module rr_pick
    import noc_pkg::*;
#(
    parameter  int unsigned N_REQ = noc_pkg::N_REQ,
    localparam int unsigned PTR_W = ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] idx
);

    logic             found;
    logic [PTR_W-1:0] cand;

    // Walk candidates in rotated order; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            cand = PTR_W'((32'(ptr) + j) % N_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/vc_output_scheduler.sv
// Per-output-port scheduler: round-robin arbitration into the internal VC
// buffer (VC index == polarity) while the external VC (~polarity) drains to
// the downstream link over the so/ro handshake.
//   clk      : clock, rising edge
//   reset    : synchronous, active-high
//   polarity : router phase bit, toggles every cycle
//   bus      : req/data_in/grant and so/ro/data_out/vc_full bundle
module vc_output_scheduler
    import noc_pkg::*;
#(
    parameter  int unsigned DATA_W = noc_pkg::DATA_W,
    parameter  int unsigned N_REQ  = noc_pkg::N_REQ,
    localparam int unsigned PTR_W  = ptr_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   polarity,
    vc_output_scheduler_if.master  bus
);

    logic                    iv;
    logic                    ev;
    logic [DATA_W-1:0]       vc_buf [2];
    logic [1:0]              full_q;
    logic [PTR_W-1:0]        ptr_q [2];

    logic [N_REQ-1:0]        req_eff;
    logic [N_REQ-1:0]        gnt;
    logic [PTR_W-1:0]        idx;
    logic [PTR_W-1:0]        ptr_next;
    logic [DATA_W-1:0]       flits [N_REQ];
    logic [DATA_W-1:0]       win_flit;
    logic                    granted;
    logic                    send;

    assign iv = polarity;
    assign ev = ~polarity;

    // A full internal VC blocks arbitration entirely; requesters keep their place.
    assign req_eff = full_q[iv] ? '0 : bus.req;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req (req_eff),
        .ptr (ptr_q[iv]),
        .gnt (gnt),
        .idx (idx)
    );

    // Unpack input flits so the winner can be selected by index.
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign flits[g] = bus.data_in[g*DATA_W +: DATA_W];
    end

    assign win_flit = flits[idx];
    assign granted  = |gnt;
    assign ptr_next = PTR_W'((32'(idx) + 1) % N_REQ);
    assign send     = full_q[ev] & bus.ro;

    assign bus.grant    = gnt;
    assign bus.so       = send;
    assign bus.data_out = vc_buf[ev];
    assign bus.vc_full  = full_q;

    // Fill touches only the internal VC and drain only the external VC, so both
    // may happen on the same edge. Drained flit values are held, not cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= '0;
            vc_buf[0] <= '0;
            vc_buf[1] <= '0;
            ptr_q[0]  <= '0;
            ptr_q[1]  <= '0;
        end else begin
            if (granted) begin
                vc_buf[iv] <= win_flit;
                full_q[iv] <= 1'b1;
                ptr_q[iv]  <= ptr_next;
            end
            if (send) begin
                full_q[ev] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vc_output_scheduler.sv
// Self-checking bench for vc_output_scheduler: a behavioural reference of the
// two VC buffers and pointers plus per-VC scoreboards of granted flits that are
// compared against data_out when the link sends.
module tb_vc_output_scheduler;

    localparam int unsigned DW = 64;
    localparam int unsigned NR = 4;

    logic clk = 1'b0;
    logic reset;
    logic polarity;

    vc_output_scheduler_if #(.DATA_W(DW), .N_REQ(NR)) bus ();

    vc_output_scheduler #(.DATA_W(DW), .N_REQ(NR)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] m_buf [2];
    logic [1:0]    m_full;
    int unsigned   m_ptr [2];
    logic [DW-1:0] sb0 [$];
    logic [DW-1:0] sb1 [$];

    function automatic logic [NR-1:0] m_grant();
        logic v;
        int unsigned k;
        v = polarity;
        if (m_full[v] || bus.req == '0) return '0;
        for (int unsigned j = 0; j < NR; j++) begin
            k = (m_ptr[v] + j) % NR;
            if (bus.req[k]) return NR'(1) << k;
        end
        return '0;
    endfunction

    function automatic logic m_so();
        logic e;
        e = ~polarity;
        return m_full[e] & bus.ro;
    endfunction

    function automatic logic [DW-1:0] sb_front(input logic v);
        if (v) return (sb1.size() > 0) ? sb1[0] : 'x;
        return (sb0.size() > 0) ? sb0[0] : 'x;
    endfunction

    task automatic set_in(input logic pol, input logic [NR-1:0] r, input logic rv);
        polarity = pol;
        bus.req  = r;
        bus.ro   = rv;
        for (int i = 0; i < NR; i++) bus.data_in[i*DW +: DW] = {32'(cyc), 24'h0, 8'(i)};
    endtask

    // Advance one clock edge and update the reference model with the inputs seen there.
    task automatic tick();
        logic [NR-1:0] g;
        logic          s;
        logic          v;
        int unsigned   k;
        logic [DW-1:0] f;
        g = m_grant();
        s = m_so();
        v = polarity;
        k = 0;
        @(posedge clk);
        if (reset) begin
            m_full   = '0;
            m_buf[0] = '0;
            m_buf[1] = '0;
            m_ptr[0] = 0;
            m_ptr[1] = 0;
            sb0.delete();
            sb1.delete();
        end else begin
            if (g != '0) begin
                for (int unsigned j = 0; j < NR; j++) if (g[j]) k = j;
                f = bus.data_in[k*DW +: DW];
                m_buf[v]  = f;
                m_full[v] = 1'b1;
                m_ptr[v]  = (k + 1) % NR;
                if (v) sb1.push_back(f); else sb0.push_back(f);
            end
            if (s) begin
                m_full[!v] = 1'b0;
                if (!v) begin if (sb1.size() > 0) void'(sb1.pop_front()); end
                else    begin if (sb0.size() > 0) void'(sb0.pop_front()); end
            end
        end
        #1;
        cyc++;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        set_in(1'b0, '0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b0, '0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.vc_full !== 2'b00) begin failures++; $display("FAIL reset_vc_full: got %b expected 00", bus.vc_full); end
        checks++; if (bus.so !== 1'b0) begin failures++; $display("FAIL reset_so: got %b expected 0", bus.so); end
        checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL reset_data_out: got %h expected 0", bus.data_out); end
        checks++; if (bus.grant !== '0) begin failures++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
        tick();
    endtask

    task automatic test_single();
        pulse_reset();
        set_in(1'b0, 4'b0001, 1'b1);
        bus.data_in[DW-1:0] = 64'hA5;
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b expected 0001", bus.grant); end
        tick();
        set_in(1'b1, 4'b0000, 1'b1);
        @(negedge clk);
        checks++; if (bus.so !== 1'b1) begin failures++; $display("FAIL single_so: got %b expected 1", bus.so); end
        checks++; if (bus.data_out !== 64'hA5) begin failures++; $display("FAIL single_data: got %h expected a5", bus.data_out); end
        tick();
        set_in(1'b0, 4'b0000, 1'b1);
        @(negedge clk);
        checks++; if (bus.vc_full !== 2'b00) begin failures++; $display("FAIL single_vc_full: got %b expected 00", bus.vc_full); end
        tick();
    endtask

    task automatic test_rotate();
        logic [NR-1:0] exp_g;
        logic [DW-1:0] exp_d;
        pulse_reset();
        for (int c = 0; c < 8; c++) begin
            set_in((c % 2) == 1, 4'b1111, 1'b1);
            exp_g = NR'(1) << (c / 2);
            @(negedge clk);
            checks++; if (bus.grant !== exp_g) begin failures++; $display("FAIL rotate_grant c=%0d: got %b expected %b", c, bus.grant, exp_g); end
            checks++; if (bus.so !== (c != 0)) begin failures++; $display("FAIL rotate_so c=%0d: got %b expected %b", c, bus.so, (c != 0)); end
            if (c != 0) begin
                exp_d = sb_front(~polarity);
                checks++; if (bus.data_out !== exp_d) begin failures++; $display("FAIL rotate_data c=%0d: got %h expected %h", c, bus.data_out, exp_d); end
            end
            tick();
        end
    endtask

    task automatic test_ro_stall();
        logic [DW-1:0] held;
        pulse_reset();
        set_in(1'b0, 4'b0001, 1'b0);
        held = bus.data_in[DW-1:0];
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL stall_fill: got %b expected 0001", bus.grant); end
        tick();
        for (int c = 0; c < 6; c++) begin
            set_in((c % 2) == 0, 4'b0001, 1'b0);
            @(negedge clk);
            checks++; if (bus.so !== 1'b0) begin failures++; $display("FAIL stall_so c=%0d: got %b expected 0", c, bus.so); end
            if (polarity) begin
                checks++; if (bus.data_out !== held) begin failures++; $display("FAIL stall_data c=%0d: got %h expected %h", c, bus.data_out, held); end
            end else begin
                checks++; if (bus.grant !== '0) begin failures++; $display("FAIL stall_grant c=%0d: got %b expected 0000", c, bus.grant); end
            end
            tick();
        end
        set_in(1'b1, 4'b0001, 1'b1);
        @(negedge clk);
        checks++; if (bus.so !== 1'b1) begin failures++; $display("FAIL stall_release_so: got %b expected 1", bus.so); end
        checks++; if (bus.data_out !== held) begin failures++; $display("FAIL stall_release_data: got %h expected %h", bus.data_out, held); end
        tick();
        set_in(1'b0, 4'b0001, 1'b1);
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL stall_resume_grant: got %b expected 0001", bus.grant); end
        checks++; if (bus.so !== m_so()) begin failures++; $display("FAIL stall_resume_so: got %b expected %b", bus.so, m_so()); end
        tick();
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] exp_d;
        pulse_reset();
        set_in(1'b1, 4'b0001, 1'b0);
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL simul_fill_vc1: got %b expected 0001", bus.grant); end
        tick();
        set_in(1'b0, 4'b0100, 1'b1);
        exp_d = sb_front(1'b1);
        @(negedge clk);
        checks++; if (bus.so !== 1'b1) begin failures++; $display("FAIL simul_so: got %b expected 1", bus.so); end
        checks++; if (bus.grant !== 4'b0100) begin failures++; $display("FAIL simul_grant: got %b expected 0100", bus.grant); end
        checks++; if (bus.data_out !== exp_d) begin failures++; $display("FAIL simul_data: got %h expected %h", bus.data_out, exp_d); end
        tick();
        set_in(1'b1, 4'b0000, 1'b0);
        @(negedge clk);
        checks++; if (bus.vc_full !== 2'b01) begin failures++; $display("FAIL simul_vc_full: got %b expected 01", bus.vc_full); end
        tick();
    endtask

    task automatic test_ptr_skip();
        pulse_reset();
        set_in(1'b0, 4'b0010, 1'b1);
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0010) begin failures++; $display("FAIL skip_setup: got %b expected 0010", bus.grant); end
        tick();
        set_in(1'b1, 4'b0000, 1'b1);
        tick();
        set_in(1'b0, 4'b0011, 1'b1);
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL skip_wrap: got %b expected 0001", bus.grant); end
        tick();
        set_in(1'b1, 4'b0000, 1'b1);
        tick();
        set_in(1'b0, 4'b0011, 1'b1);
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0010) begin failures++; $display("FAIL skip_ptr_after: got %b expected 0010", bus.grant); end
        tick();
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        set_in(1'b0, 4'b0001, 1'b0);
        tick();
        set_in(1'b1, 4'b0010, 1'b0);
        tick();
        set_in(1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        checks++; if (bus.vc_full !== 2'b11) begin failures++; $display("FAIL rmid_both_full: got %b expected 11", bus.vc_full); end
        tick();
        reset = 1'b1;
        set_in(1'b1, 4'b1111, 1'b1);
        tick();
        reset = 1'b0;
        set_in(1'b0, 4'b0000, 1'b1);
        @(negedge clk);
        checks++; if (bus.vc_full !== 2'b00) begin failures++; $display("FAIL rmid_vc_full: got %b expected 00", bus.vc_full); end
        checks++; if (bus.so !== 1'b0) begin failures++; $display("FAIL rmid_so: got %b expected 0", bus.so); end
        checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL rmid_data: got %h expected 0", bus.data_out); end
        tick();
        set_in(1'b1, 4'b0000, 1'b1);
        @(negedge clk);
        checks++; if (bus.so !== 1'b0) begin failures++; $display("FAIL rmid_no_emit: got %b expected 0", bus.so); end
        checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL rmid_data_odd: got %h expected 0", bus.data_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] exp_g;
        logic          exp_s;
        logic [DW-1:0] exp_d;
        pulse_reset();
        for (int c = 0; c < 300; c++) begin
            set_in((c % 2) == 1, NR'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            exp_g = m_grant();
            exp_s = m_so();
            @(negedge clk);
            checks++; if (bus.grant !== exp_g) begin failures++; $display("FAIL b2b_grant c=%0d: got %b expected %b", c, bus.grant, exp_g); end
            checks++; if (bus.so !== exp_s) begin failures++; $display("FAIL b2b_so c=%0d: got %b expected %b", c, bus.so, exp_s); end
            if (exp_s) begin
                exp_d = sb_front(~polarity);
                checks++; if (bus.data_out !== exp_d) begin failures++; $display("FAIL b2b_data c=%0d: got %h expected %h", c, bus.data_out, exp_d); end
            end
            checks++; if (bus.vc_full !== m_full) begin failures++; $display("FAIL b2b_vc_full c=%0d: got %b expected %b", c, bus.vc_full, m_full); end
            tick();
        end
    endtask

    initial begin
        reset       = 1'b1;
        polarity    = 1'b0;
        bus.req     = '0;
        bus.ro      = 1'b0;
        bus.data_in = '0;
        m_full      = '0;
        m_buf[0]    = '0;
        m_buf[1]    = '0;
        m_ptr[0]    = 0;
        m_ptr[1]    = 0;
        test_reset();
        test_single();
        test_rotate();
        test_ro_stall();
        test_simultaneous();
        test_ptr_skip();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
